cmd_sequencer: RTL

//  Parametrised, self-checking command sequencer for the Knight's Tour system.

---
 rtl/kt_seq_pkg.sv | 20 ++
 rtl/seq_timeout_tmr.sv | 32 +++
 rtl/cmd_sequencer.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/kt_seq_pkg.sv
// Shared types and constants for the Knight's Tour command sequencer.
//   seq_state_t : sequencer FSM states
//   KT_ACK      : positive acknowledge byte returned by the robot
//   KT_CMD_CAL  : calibrate command, the usual first entry of a sequence
package kt_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SEND,
    S_WAIT_SENT,
    S_WAIT_RESP,
    S_CHECK,
    S_FIN
  } seq_state_t;

  localparam logic [7:0]  KT_ACK     = 8'hA5;
  localparam logic [15:0] KT_CMD_CAL = 16'h2000;

endpackage

// File: rtl/seq_timeout_tmr.sv
// Response timeout counter for the command sequencer.
//   clk, rst_n : clock, async active-low reset
//   clr        : restart the count (the clearing cycle itself is count 0)
//   en         : advance the count
//   tc         : high while enabled at count TMO_CYC-1
// Parameters: TMO_W counter width, TMO_CYC cycles allowed (>= 2).
module seq_timeout_tmr #(
  parameter int TMO_W   = 24,
  parameter int TMO_CYC = 8_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [TMO_W-1:0] TC_VAL = TMO_W'(TMO_CYC - 1);

  logic [TMO_W-1:0] cnt;

  // The clearing cycle counts as cycle 0, so the register restarts at 1.
  // The count parks at the terminal value until the next clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      cnt <= '0;
    else if (clr)                    cnt <= TMO_W'(1);
    else if (en && (cnt != TC_VAL))  cnt <= cnt + TMO_W'(1);
  end

  assign tc = en && (cnt == TC_VAL);

endmodule

// File: rtl/cmd_sequencer.sv
// Command sequencer: replays a programmed list of commands into remoteComm,
// waits for each response (with timeout) and compares it to an expected byte.
//   prog_we/prog_addr/prog_cmd/prog_exp : sequence memory write port (idle only)
//   seq_len, start, abort               : run control
//   cmd, send_cmd / cmd_sent, resp_rdy, resp : remoteComm handshake
//   busy, done, pass, fail_cnt, fail_idx, tmo_err : run status
// Build option: define SEQ_RETRY_EN to re-send an entry once after a timeout;
// this adds the retry_cnt output (retries in the last run).
module cmd_sequencer
  import kt_seq_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int CMD_W       = 16,
  parameter int RESP_W      = 8,
  parameter int TMO_W       = 24,
  parameter int TMO_CYC     = 8_000_000,
  parameter int STOP_ON_ERR = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     prog_we,
  input  logic [$clog2(DEPTH)-1:0] prog_addr,
  input  logic [CMD_W-1:0]         prog_cmd,
  input  logic [RESP_W-1:0]        prog_exp,
  input  logic [$clog2(DEPTH):0]   seq_len,
  input  logic                     start,
  input  logic                     abort,
  output logic [CMD_W-1:0]         cmd,
  output logic                     send_cmd,
  input  logic                     cmd_sent,
  input  logic                     resp_rdy,
  input  logic [RESP_W-1:0]        resp,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [$clog2(DEPTH):0]   fail_cnt,
  output logic [$clog2(DEPTH)-1:0] fail_idx,
  output logic                     tmo_err
`ifdef SEQ_RETRY_EN
  ,
  output logic [$clog2(DEPTH):0]   retry_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  function automatic logic [LW-1:0] sat_inc(input logic [LW-1:0] v);
    return (v == '1) ? v : v + LW'(1);
  endfunction

  seq_state_t        state, state_d;
  logic [CMD_W-1:0]  mem_cmd [DEPTH];
  logic [RESP_W-1:0] mem_exp [DEPTH];
  logic [AW-1:0]     idx;
  logic [LW-1:0]     len_q;
  logic [RESP_W-1:0] exp_q, resp_q;
  logic              tmo_flag, rdy_q, resp_rise, is_last, chk_fail, tc;
  logic              go_run, go_empty, do_load, tmr_clr, tmr_en, cap_resp;
  logic              set_tmo, do_retry, rec_fail, idx_inc, fin_chk, tmo_hit;
`ifdef SEQ_RETRY_EN
  logic              retried;
`endif

  assign resp_rise = resp_rdy & ~rdy_q;
  assign is_last   = ({1'b0, idx} == (len_q - LW'(1)));
  assign chk_fail  = tmo_flag || (resp_q != exp_q);
  assign send_cmd  = (state == S_SEND);
  assign done      = (state == S_FIN);
  assign busy      = (state != S_IDLE) && (state != S_FIN);

  seq_timeout_tmr #(.TMO_W(TMO_W), .TMO_CYC(TMO_CYC)) u_tmr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (tmr_clr),
    .en    (tmr_en),
    .tc    (tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d  = state;
    go_run   = 1'b0;
    go_empty = 1'b0;
    do_load  = 1'b0;
    tmr_clr  = 1'b0;
    tmr_en   = 1'b0;
    cap_resp = 1'b0;
    set_tmo  = 1'b0;
    do_retry = 1'b0;
    rec_fail = 1'b0;
    idx_inc  = 1'b0;
    fin_chk  = 1'b0;
    tmo_hit  = 1'b0;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            if (seq_len == '0) begin
              go_empty = 1'b1;
              state_d  = S_FIN;
            end else begin
              go_run  = 1'b1;
              state_d = S_LOAD;
            end
          end
        end
        S_LOAD: begin
          do_load = 1'b1;
          state_d = S_SEND;
        end
        S_SEND: begin
          tmr_clr = 1'b1;
          state_d = S_WAIT_SENT;
        end
        S_WAIT_SENT: begin
          tmr_en = 1'b1;
          if (cmd_sent) state_d = S_WAIT_RESP;
          else if (tc)  tmo_hit = 1'b1;
        end
        S_WAIT_RESP: begin
          tmr_en = 1'b1;
          // A response arriving on the terminal-count cycle still counts.
          if (resp_rise) begin
            cap_resp = 1'b1;
            state_d  = S_CHECK;
          end else if (tc) begin
            tmo_hit = 1'b1;
          end
        end
        S_CHECK: begin
          rec_fail = chk_fail;
          if ((chk_fail && (STOP_ON_ERR != 0)) || is_last) begin
            fin_chk = 1'b1;
            state_d = S_FIN;
          end else begin
            idx_inc = 1'b1;
            state_d = S_LOAD;
          end
        end
        S_FIN:   state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
      if (tmo_hit) begin
`ifdef SEQ_RETRY_EN
        // cmd still holds the entry, so a retry goes straight back to SEND.
        if (!retried) begin
          do_retry = 1'b1;
          state_d  = S_SEND;
        end else begin
          set_tmo = 1'b1;
          state_d = S_CHECK;
        end
`else
        set_tmo = 1'b1;
        state_d = S_CHECK;
`endif
      end
    end
  end

  // Sequence memory and compare operands carry no reset.
  always_ff @(posedge clk) begin
    if (prog_we && !busy) begin
      mem_cmd[prog_addr] <= prog_cmd;
      mem_exp[prog_addr] <= prog_exp;
    end
    if (do_load)  exp_q  <= mem_exp[idx];
    if (cap_resp) resp_q <= resp;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd      <= '0;
      pass     <= 1'b0;
      fail_cnt <= '0;
      fail_idx <= '0;
      tmo_err  <= 1'b0;
      idx      <= '0;
      len_q    <= '0;
      tmo_flag <= 1'b0;
      rdy_q    <= 1'b0;
`ifdef SEQ_RETRY_EN
      retried   <= 1'b0;
      retry_cnt <= '0;
`endif
    end else begin
      rdy_q <= resp_rdy;
      if (abort) pass <= 1'b0;
      if (go_run || go_empty) begin
        pass     <= go_empty;
        fail_cnt <= '0;
        fail_idx <= '0;
        tmo_err  <= 1'b0;
        idx      <= '0;
        len_q    <= seq_len;
`ifdef SEQ_RETRY_EN
        retry_cnt <= '0;
`endif
      end
      if (do_load) begin
        cmd      <= mem_cmd[idx];
        tmo_flag <= 1'b0;
`ifdef SEQ_RETRY_EN
        retried  <= 1'b0;
`endif
      end
      if (set_tmo) tmo_flag <= 1'b1;
`ifdef SEQ_RETRY_EN
      if (do_retry) begin
        retried   <= 1'b1;
        retry_cnt <= sat_inc(retry_cnt);
      end
`endif
      if (rec_fail) begin
        fail_cnt <= sat_inc(fail_cnt);
        if (fail_cnt == '0) begin
          fail_idx <= idx;
          tmo_err  <= tmo_flag;
        end
      end
      if (idx_inc) idx  <= idx + AW'(1);
      if (fin_chk) pass <= (fail_cnt == '0) && !chk_fail;
    end
  end

endmodule
